// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, NRD combinational read ports and a busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_reg,
  output logic [ADDR_W-1:0]     busy_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf_q [Depth];
  logic [DATA_W-1:0] rf_d [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [ADDR_W-1:0] busy_cnt_q, busy_cnt_d;

  logic wr0_act, wr1_act;
  assign wr0_act = we0 && (waddr0 != '0);
  assign wr1_act = we1 && (waddr1 != '0);

  // Port 1 is applied last so it wins an address collision; issue is applied
  // after the write-clear so a same-cycle issue keeps the register busy.
  always_comb begin
    int unsigned cnt;
    rf_d   = rf_q;
    busy_d = busy_q;
    cnt    = 0;
    if (wr0_act) begin
      rf_d[waddr0]   = wdata0;
      busy_d[waddr0] = 1'b0;
    end
    if (wr1_act) begin
      rf_d[waddr1]   = wdata1;
      busy_d[waddr1] = 1'b0;
    end
    if (iss_valid && (iss_reg != '0)) begin
      busy_d[iss_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (busy_d[i]) cnt++;
    end
    busy_cnt_d = ADDR_W'(cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q       <= '{default: '0};
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      rf_q       <= rf_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  logic [ADDR_W-1:0] ra [NRD];

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      ra[k] = raddr[k*ADDR_W +: ADDR_W];
      if (ra[k] != '0) begin
        rdata[k*DATA_W +: DATA_W] = rf_q[ra[k]];
        rbusy[k]                  = busy_q[ra[k]];
      end
`ifdef REG_FILE_BYPASS_EN
      if (wr0_act && (waddr0 == ra[k])) begin
        rdata[k*DATA_W +: DATA_W] = wdata0;
        rbusy[k]                  = 1'b0;
      end
      if (wr1_act && (waddr1 == ra[k])) begin
        rdata[k*DATA_W +: DATA_W] = wdata1;
        rbusy[k]                  = 1'b0;
      end
`endif
    end
  end

endmodule
